// File: rtl/dregister_pipe_if.sv
// Handshake bundle for dregister_pipe: upstream push side, downstream pop side and occupancy.
// The i_flush signal exists only when DREGISTER_PIPE_FLUSH_EN is defined.
interface dregister_pipe_if #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] i_data;
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] o_data;
   logic             o_valid;
   logic             i_ready;
   logic [CW-1:0]    o_count;
`ifdef DREGISTER_PIPE_FLUSH_EN
   logic             i_flush;

   modport slave  (input  i_data, i_valid, i_ready, i_flush,
                   output o_ready, o_data, o_valid, o_count);
   modport master (output i_data, i_valid, i_ready, i_flush,
                   input  o_ready, o_data, o_valid, o_count);
`else
   modport slave  (input  i_data, i_valid, i_ready,
                   output o_ready, o_data, o_valid, o_count);
   modport master (output i_data, i_valid, i_ready,
                   input  o_ready, o_data, o_valid, o_count);
`endif
endinterface

// File: rtl/dregister_pipe.sv
// Elastic DEPTH-stage register pipeline with per-stage valid bits and collapsing bubbles.
// Optional synchronous flush is enabled by defining DREGISTER_PIPE_FLUSH_EN.
module dregister_pipe #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input logic             i_clk,
   input logic             i_rstn,
   dregister_pipe_if.slave bus
);
   logic [DEPTH-1:0] r_valid;
   logic [WIDTH-1:0] r_data [DEPTH];

   logic [DEPTH-1:0] w_rdy;
   logic [DEPTH-1:0] w_srcValid;
   logic [WIDTH-1:0] w_srcData [DEPTH];
   logic [CW-1:0]    w_count;
   logic             w_flush;

`ifdef DREGISTER_PIPE_FLUSH_EN
   assign w_flush = bus.i_flush;
`else
   assign w_flush = 1'b0;
`endif

   // A stage can load when it or any stage downstream of it is empty, or the sink is taking data.
   for (genvar k = 0; k < DEPTH; k++) begin : g_rdy
      assign w_rdy[k] = bus.i_ready | ~(&r_valid[DEPTH-1:k]);
   end

   always_comb begin
      w_srcValid[0] = bus.i_valid;
      w_srcData[0]  = bus.i_data;
      for (int k = 1; k < DEPTH; k++) begin
         w_srcValid[k] = r_valid[k-1];
         w_srcData[k]  = r_data[k-1];
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_valid <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            r_data[k] <= '0;
         end
      end else if (w_flush) begin
         r_valid <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (w_rdy[k]) begin
               r_valid[k] <= w_srcValid[k];
               if (w_srcValid[k]) begin
                  r_data[k] <= w_srcData[k];
               end
            end
         end
      end
   end

   always_comb begin
      w_count = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_count = w_count + CW'(r_valid[k]);
      end
   end

   assign bus.o_ready = w_rdy[0] & ~w_flush;
   assign bus.o_valid = r_valid[DEPTH-1] & ~w_flush;
   assign bus.o_data  = r_data[DEPTH-1];
   assign bus.o_count = w_count;
endmodule
